// File: rtl/instr_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: FSM state encodings,
// the queue entry layout and the fetch arithmetic constants.
package instr_fetch_queue_pkg;

  typedef enum logic [1:0] {
    FQ_RUN      = 2'd0,
    FQ_WAIT_ACK = 2'd1,
    FQ_DISCARD  = 2'd2
  } fq_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fq_entry_t;

  localparam logic [31:0] BUBBLE_WORD   = 32'h0000_0000;
  localparam logic [31:0] PC_INC        = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'h0000_0003;

endpackage

// File: rtl/instr_fetch_queue_queue.sv
// Prefetch FIFO of {instr, pc} entries. Clear has priority over push/pop.
// Read data is the head entry, available combinationally from storage.
module instr_fetch_queue_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  fq_entry_t                wr_data,
  output fq_entry_t                rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fq_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

  // storage write; entries need no reset since count gates their use
  always_ff @(posedge CLK) begin
    if (push && !clear) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: PC generation, single-outstanding memory
// request FSM, prefetch queue and the registered IF/ID outputs.
// Optional FETCH_TRACE_EN prints fetch activity in simulation only.
//
//  state       | meaning
//  FQ_RUN      | idle, issue a request when the queue has room
//  FQ_WAIT_ACK | request outstanding, Req/Addr held until Ack
//  FQ_DISCARD  | flushed while outstanding, drop the returning Ack
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0040_0000,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] Alt_PC_IN,
  output logic [31:0] Instr_Addr_OUT,
  output logic        Instr_Req_OUT,
  input  logic        Instr_Ack_IN,
  input  logic [31:0] Instr_Data_IN,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr_PC_OUT,
  output logic [31:0] Instr_PC_Plus4,
  output logic        Instr_Valid_OUT
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  fq_state_t       state;
  logic [31:0]     pc;
  logic            push;
  logic            pop;
  logic            q_full;
  logic            q_empty;
  logic [CW-1:0]   q_count;
  fq_entry_t       q_head;
  fq_entry_t       q_wr;
  logic            unused_full;

  // space is reserved at issue, so an accepted Ack can always be pushed
  assign push        = (state == FQ_WAIT_ACK) && Instr_Ack_IN && !FLUSH;
  assign pop         = !FLUSH && !STALL && !q_empty;
  assign q_wr        = '{instr: Instr_Data_IN, pc: Instr_Addr_OUT};
  assign unused_full = q_full;

  instr_fetch_queue_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .CLK     (CLK),
    .RESET   (RESET),
    .push    (push),
    .pop     (pop),
    .clear   (FLUSH),
    .wr_data (q_wr),
    .rd_data (q_head),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count)
  );

  // fetch FSM with registered request outputs; FLUSH overrides everything
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state          <= FQ_RUN;
      pc             <= RESET_PC;
      Instr_Req_OUT  <= 1'b0;
      Instr_Addr_OUT <= 32'h0;
    end else if (FLUSH) begin
      pc            <= Alt_PC_IN & ~PC_ALIGN_MASK;
      Instr_Req_OUT <= 1'b0;
      state         <= ((state != FQ_RUN) && !Instr_Ack_IN) ? FQ_DISCARD : FQ_RUN;
    end else begin
      case (state)
        FQ_RUN: begin
          if (q_count < CW'(QUEUE_DEPTH)) begin
            Instr_Req_OUT  <= 1'b1;
            Instr_Addr_OUT <= pc;
            state          <= FQ_WAIT_ACK;
          end
        end
        FQ_WAIT_ACK: begin
          if (Instr_Ack_IN) begin
            pc            <= pc + PC_INC;
            Instr_Req_OUT <= 1'b0;
            state         <= FQ_RUN;
          end
        end
        FQ_DISCARD: begin
          if (Instr_Ack_IN) state <= FQ_RUN;
        end
        default: state <= FQ_RUN;
      endcase
    end
  end

  // IF/ID output register: flush bubbles, stall holds, otherwise pop head
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Instr1_OUT      <= BUBBLE_WORD;
      Instr_PC_OUT    <= 32'h0;
      Instr_PC_Plus4  <= 32'h0;
      Instr_Valid_OUT <= 1'b0;
    end else if (FLUSH) begin
      Instr1_OUT      <= BUBBLE_WORD;
      Instr_PC_OUT    <= 32'h0;
      Instr_PC_Plus4  <= 32'h0;
      Instr_Valid_OUT <= 1'b0;
    end else if (!STALL) begin
      if (!q_empty) begin
        Instr1_OUT      <= q_head.instr;
        Instr_PC_OUT    <= q_head.pc;
        Instr_PC_Plus4  <= q_head.pc + PC_INC;
        Instr_Valid_OUT <= 1'b1;
      end else begin
        Instr1_OUT      <= BUBBLE_WORD;
        Instr_PC_OUT    <= 32'h0;
        Instr_PC_Plus4  <= 32'h0;
        Instr_Valid_OUT <= 1'b0;
      end
    end
  end

`ifdef FETCH_TRACE_EN
  // simulation-only activity trace
  always @(posedge CLK) begin
    if (RESET) begin
      if (!FLUSH && state == FQ_RUN && q_count < CW'(QUEUE_DEPTH))
        $display("Fetch req @%x", pc);
      if (push)
        $display("Fetch ack @%x data %x", Instr_Addr_OUT, Instr_Data_IN);
      if (pop)
        $display("Fetch deliver @%x instr %x", q_head.pc, q_head.instr);
      if (FLUSH)
        $display("Fetch flush -> %x", Alt_PC_IN & ~PC_ALIGN_MASK);
      if (STALL && !FLUSH)
        $display("Fetch stall");
    end
  end
`endif

endmodule
